letter_tx_queue: RTL and testbench

//  Parametrised letter queue between the enigma encoder and the IR transmitter.
//  It stores encoded letters in a circular buffer of DEPTH entries and issues them
//  one at a time to the transmitter, using its busy signal as the handshake.
//  It also reports occupancy, full, empty and overflow for debug and display.

---
 rtl/letter_tx_queue.sv | 125 ++++++++++++
 tb/tb_letter_tx_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/letter_tx_queue.sv
// Letter queue between the enigma encoder and the IR transmitter: circular buffer
// with registered-read RAM, issued one letter at a time using tx_busy_in as handshake.
module letter_tx_queue #(
   parameter int DATA_WIDTH   = 5,
   parameter int DEPTH        = 1000,
   parameter int EDGE_WRITE   = 1,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         data_valid_in,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         pause_in,
   input  logic                         tx_busy_in,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         data_valid_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out,
   output logic [$clog2(DEPTH)-1:0]     wr_addr_out,
   output logic                         empty_out,
   output logic                         full_out,
   output logic                         overflow_out
);

   // state       | meaning
   // S_IDLE      | waiting for a stored letter and pause_in low; RAM addressed at rd_ptr
   // S_FETCH     | RAM read latency cycle
   // S_ISSUE     | data_valid_out strobe, timeout counter loaded
   // S_WAIT_BUSY | waiting for tx_busy_in to rise, re-issue on timeout
   // S_WAIT_DONE | waiting for tx_busy_in to fall, then retire the letter

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [TW-1:0]         tmo_cnt;
   logic                  prev_valid;
   logic                  write_req, write_acc, done;

   assign write_req      = (EDGE_WRITE != 0) ? (data_valid_in && !prev_valid) : data_valid_in;
   assign write_acc      = write_req && !full_out;
   assign done           = (state == S_WAIT_DONE) && !tx_busy_in;
   assign empty_out      = (count_out == '0);
   assign full_out       = (count_out == CW'(DEPTH));
   assign data_valid_out = (state == S_ISSUE);
   assign wr_addr_out    = wr_ptr;

   always_ff @(posedge clk_in) begin
      if (write_acc) begin
         mem[wr_ptr] <= data_in;
      end
      rd_data <= mem[rd_ptr];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (!empty_out && !pause_in) state_nxt = S_FETCH;
         S_FETCH:     state_nxt = S_ISSUE;
         S_ISSUE:     state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (tx_busy_in)          state_nxt = S_WAIT_DONE;
            else if (tmo_cnt == '0)  state_nxt = S_ISSUE;
         end
         S_WAIT_DONE: if (!tx_busy_in) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state        <= S_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_out    <= '0;
         tmo_cnt      <= '0;
         prev_valid   <= 1'b0;
         data_out     <= '0;
         overflow_out <= 1'b0;
      end else begin
         state      <= state_nxt;
         prev_valid <= data_valid_in;

         if (write_acc) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (write_req && full_out) begin
            overflow_out <= 1'b1;
         end
         if (done) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end

         case ({write_acc, done})
            2'b10:   count_out <= count_out + CW'(1);
            2'b01:   count_out <= count_out - CW'(1);
            default: count_out <= count_out;
         endcase

         // Down-counter: WAIT_BUSY lasts BUSY_TIMEOUT cycles before a re-issue
         if (state == S_ISSUE) begin
            tmo_cnt <= TW'(BUSY_TIMEOUT - 1);
         end else if (state == S_WAIT_BUSY && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TW'(1);
         end

         // rd_data still holds mem[rd_ptr] on a re-issue since rd_ptr has not moved
         if (state_nxt == S_ISSUE) begin
            data_out <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_letter_tx_queue.sv
// Scoreboard bench for letter_tx_queue (DEPTH=4, BUSY_TIMEOUT=8, edge writes).
module tb_letter_tx_queue;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic       data_valid_in = 1'b0;
   logic [4:0] data_in = '0;
   logic       pause_in = 1'b0;
   logic       tx_busy_in = 1'b0;
   logic [4:0] data_out;
   logic       data_valid_out;
   logic [2:0] count_out;
   logic [1:0] wr_addr_out;
   logic       empty_out, full_out, overflow_out;

   int checks = 0;
   int errors = 0;
   int strobes = 0;
   int exp_q[$];

   letter_tx_queue #(
      .DATA_WIDTH(5), .DEPTH(4), .EDGE_WRITE(1), .BUSY_TIMEOUT(8)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in), .data_in(data_in),
      .pause_in(pause_in), .tx_busy_in(tx_busy_in), .data_out(data_out),
      .data_valid_out(data_valid_out), .count_out(count_out), .wr_addr_out(wr_addr_out),
      .empty_out(empty_out), .full_out(full_out), .overflow_out(overflow_out)
   );

   always #5 clk_in = ~clk_in;

   // Monitor: every strobe must match the next expected letter
   always @(negedge clk_in) begin
      if (rst_in && data_valid_out) begin
         strobes++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: data_out=%0d, required no strobe", data_out);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (data_out !== 5'(e)) begin
               errors++;
               $display("FAIL strobe_data: data_out=%0d, required %0d", data_out, e);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d, required=%0d", name, act, exp);
      end
   endtask

   task automatic write_letter(input int d);
      data_in       = 5'(d);
      data_valid_in = 1'b1;
      tick(1);
      data_valid_in = 1'b0;
      tick(1);
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      while (!data_valid_out && n < 50) begin
         tick(1);
         n++;
      end
      if (!data_valid_out) begin
         checks++;
         errors++;
         $display("FAIL strobe_timeout: no strobe within %0d cycles, required a strobe", n);
      end
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      tick(2);
      rst_in = 1'b1;
   endtask

   initial begin
      int n, s0;
      tick(1);

      // 1. Reset
      do_reset();
      check("rst_count", count_out, 0);
      check("rst_empty", empty_out, 1);
      check("rst_full", full_out, 0);
      check("rst_valid", data_valid_out, 0);
      check("rst_overflow", overflow_out, 0);
      check("rst_wr_addr", wr_addr_out, 0);
      check("rst_data_out", data_out, 0);

      // 2. Single letter, valid held 10 cycles
      exp_q.push_back(7);
      data_in = 5'd7;
      data_valid_in = 1'b1;
      tick(1);
      check("single_count_after_write", count_out, 1);
      wait_strobe(n);
      check("single_issue_latency", n, 2);
      tx_busy_in = 1'b1;
      tick(7);
      data_valid_in = 1'b0;
      check("single_count_while_busy", count_out, 1);
      tick(13);
      tx_busy_in = 1'b0;
      tick(1);
      check("single_count_done", count_out, 0);
      check("single_empty_done", empty_out, 1);
      check("single_data_hold", data_out, 7);
      tick(5);
      check("single_one_strobe", strobes, 1);

      // 3. Fill and wrap
      do_reset();
      pause_in = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(i);
         write_letter(i);
      end
      check("fill_count", count_out, 4);
      check("fill_full", full_out, 1);
      check("fill_wr_addr_wrap", wr_addr_out, 0);
      check("fill_no_overflow_yet", overflow_out, 0);
      write_letter(5);
      check("drop_overflow", overflow_out, 1);
      check("drop_count", count_out, 4);
      check("drop_wr_addr", wr_addr_out, 0);
      pause_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_strobe(n);
         tx_busy_in = 1'b1;
         tick(3);
         tx_busy_in = 1'b0;
         tick(1);
         check("drain_count", count_out, 3 - i);
         check("drain_not_full", full_out, 0);
      end
      check("drain_queue_consumed", exp_q.size(), 0);
      check("overflow_sticky", overflow_out, 1);

      // 4. Write F after wrap, then busy stuck low -> timeout re-issues
      repeat (3) exp_q.push_back(6);
      write_letter(6);
      check("wrap_wr_addr", wr_addr_out, 1);
      check("wrap_count", count_out, 1);
      wait_strobe(n);
      for (int k = 0; k < 2; k++) begin
         tick(1);
         wait_strobe(n);
         check("timeout_interval", n + 1, 9);
         check("timeout_count", count_out, 1);
      end
      tx_busy_in = 1'b1;
      tick(2);
      tx_busy_in = 1'b0;
      tick(1);
      check("timeout_done_count", count_out, 0);
      check("timeout_queue_consumed", exp_q.size(), 0);

      // 5. Write lands on the completion cycle
      pause_in = 1'b1;
      write_letter(8);
      write_letter(9);
      check("simul_pre_count", count_out, 2);
      exp_q.push_back(8);
      exp_q.push_back(9);
      exp_q.push_back(10);
      pause_in = 1'b0;
      wait_strobe(n);
      tx_busy_in = 1'b1;
      tick(3);
      tx_busy_in    = 1'b0;
      data_in       = 5'd10;
      data_valid_in = 1'b1;
      pause_in      = 1'b1;
      tick(1);
      data_valid_in = 1'b0;
      check("simul_count", count_out, 2);

      // 6. Pause with count 3, then reset during WAIT_DONE
      tick(1);
      write_letter(11);
      exp_q.push_back(11);
      check("pause_count", count_out, 3);
      s0 = strobes;
      tick(20);
      check("pause_no_strobe", strobes - s0, 0);
      check("pause_count_held", count_out, 3);
      pause_in = 1'b0;
      wait_strobe(n);
      tx_busy_in = 1'b1;
      tick(3);
      do_reset();
      tx_busy_in = 1'b0;
      exp_q.delete();
      check("midrst_count", count_out, 0);
      check("midrst_empty", empty_out, 1);
      check("midrst_overflow", overflow_out, 0);
      check("midrst_wr_addr", wr_addr_out, 0);
      s0 = strobes;
      tick(20);
      check("midrst_no_strobe", strobes - s0, 0);
      check("midrst_data_out", data_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
